// File: rtl/mystery_seq_pkg.sv
// Shared types and constants for the programmable scramble sequencer.
package mystery_seq_pkg;

    // Per-step opcodes applied to the working word.
    typedef enum logic [2:0] {
        NOP    = 3'd0,
        LD_HI  = 3'd1,
        LD_LO  = 3'd2,
        SWAP   = 3'd3,
        NIBREV = 3'd4,
        PARITY = 3'd5,
        ROTL1  = 3'd6,
        XORH   = 3'd7
    } op_e;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Program that reproduces the original fixed five-step scramble.
    // Listed from step 4 down to step 0.
    localparam logic [14:0] DEF_PROG = {PARITY, NIBREV, SWAP, LD_LO, LD_HI};

    // Width of the step index; a one-step program still gets a 1-bit index.
    function automatic int step_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mystery_seq_alu.sv
// One-step datapath: applies a single opcode to the working word.
module mystery_seq_alu
    import mystery_seq_pkg::*;
#(
    parameter int HALF_W = 8
) (
    input  logic [2*HALF_W-1:0] word,
    input  logic [HALF_W-1:0]   a_r,
    input  logic [HALF_W-1:0]   b_r,
    input  op_e                 op,
    output logic [2*HALF_W-1:0] next_word
);

    localparam int W    = 2 * HALF_W;
    localparam int NIBS = W / 4;

    // Compute the word produced by the current opcode.
    always_comb begin
        // NOTE: default assignment first, so no path through the case can infer a latch.
        next_word = word;
        case (op)
            NOP:    next_word = word;
            LD_HI:  next_word[W-1:HALF_W] = a_r;
            LD_LO:  next_word[HALF_W-1:0] = b_r;
            SWAP:   next_word = {word[HALF_W-1:0], word[W-1:HALF_W]};
            NIBREV: begin
                for (int i = 0; i < NIBS; i++) begin
                    next_word[4*(NIBS-1-i) +: 4] = word[4*i +: 4];
                end
            end
            PARITY: next_word = {{(W-1){1'b0}}, ^word};
            ROTL1:  next_word = {word[W-2:0], word[W-1]};
            XORH:   next_word[HALF_W-1:0] = word[HALF_W-1:0] ^ word[W-1:HALF_W];
            default: next_word = word;
        endcase
    end

endmodule

// File: rtl/mystery_seq.sv
// Programmable scramble sequencer: captures two operands and a program,
// runs N_STEPS opcodes on a 2*HALF_W-bit word, then offers the result.
module mystery_seq
    import mystery_seq_pkg::*;
#(
    parameter int HALF_W  = 8,
    parameter int N_STEPS = 5,
    parameter int SW      = step_w(N_STEPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [HALF_W-1:0]      a_in,
    input  logic [HALF_W-1:0]      b_in,
    input  logic [3*N_STEPS-1:0]   prog,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [2*HALF_W-1:0]    out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SW-1:0]          step_idx
);

    localparam int W = 2 * HALF_W;

    if (HALF_W < 4 || (HALF_W % 4) != 0) begin : g_bad_half_w
        $error("mystery_seq: HALF_W must be a multiple of 4 and at least 4");
    end
    if (N_STEPS < 1 || N_STEPS > 8) begin : g_bad_n_steps
        $error("mystery_seq: N_STEPS must be in 1..8");
    end

    state_e               state;
    state_e               state_nxt;
    logic [W-1:0]         word;
    logic [HALF_W-1:0]    a_r;
    logic [HALF_W-1:0]    b_r;
    logic [3*N_STEPS-1:0] prog_r;
    logic [SW-1:0]        step;
    logic [W-1:0]         alu_word;
    op_e                  cur_op;
    logic                 last_step;

    assign last_step = (step == SW'(N_STEPS - 1));
    assign cur_op    = op_e'(prog_r[3*int'(step) +: 3]);

    mystery_seq_alu #(
        .HALF_W (HALF_W)
    ) u_alu (
        .word      (word),
        .a_r       (a_r),
        .b_r       (b_r),
        .op        (cur_op),
        .next_word (alu_word)
    );

    // State register; reset wins over every handshake input.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode: accept in IDLE, count through RUN, wait for the consumer in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    assign out_data = word;
    assign step_idx = step;

    // Datapath: capture operands and program on accept, apply one opcode per RUN cycle.
    always_ff @(posedge clk) begin
        // NOTE: these are a handful of flops, not a RAM, so all of them get a reset value.
        if (reset) begin
            word   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            prog_r <= '0;
            step   <= '0;
        end else if (state == IDLE && in_valid) begin
            word   <= {b_in, a_in};
            a_r    <= a_in;
            b_r    <= b_in;
            prog_r <= prog;
            step   <= '0;
        end else if (state == RUN) begin
            word <= alu_word;
            if (!last_step) step <= step + SW'(1);
        end
    end

endmodule

// File: tb/tb_mystery_seq.sv
// Scoreboard bench for mystery_seq: expected words are queued on accept and
// compared when the result handshake completes.
module tb_mystery_seq;
    import mystery_seq_pkg::*;

    localparam int HW = 8;
    localparam int N  = 5;
    localparam int W  = 2 * HW;
    localparam int SW = step_w(N);

    logic             clk;
    logic             reset;
    logic [HW-1:0]    a_in, b_in;
    logic [3*N-1:0]   prog;
    logic             in_valid, in_ready;
    logic [W-1:0]     out_data;
    logic             out_valid, out_ready;
    logic [SW-1:0]    step_idx;

    logic [15:0]      a2, b2;
    logic [3*N-1:0]   prog2;
    logic             in_valid2, in_ready2;
    logic [31:0]      out_data2;
    logic             out_valid2;
    logic [SW-1:0]    step_idx2;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     def_trace[5] = '{16'h1212, 16'h1234, 16'h3412, 16'h2143, 16'h0001};

    mystery_seq #(.HALF_W(HW), .N_STEPS(N)) dut (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .prog(prog),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .step_idx(step_idx)
    );

    mystery_seq #(.HALF_W(16), .N_STEPS(N)) dut16 (
        .clk(clk), .reset(reset), .a_in(a2), .b_in(b2), .prog(prog2),
        .in_valid(in_valid2), .in_ready(in_ready2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(1'b1), .step_idx(step_idx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent reference: run the program on a 16-bit word with shifts and masks.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [14:0] p);
        logic [15:0] w;
        logic [15:0] t;
        logic [2:0]  op;
        w = {b, a};
        for (int k = 0; k < N; k++) begin
            op = p[3*k +: 3];
            case (op)
                3'd1: w = (w & 16'h00FF) | (16'(a) << 8);
                3'd2: w = (w & 16'hFF00) | 16'(b);
                3'd3: w = (w << 8) | (w >> 8);
                3'd4: begin
                    t = '0;
                    for (int i = 0; i < 4; i++) t = (t << 4) | ((w >> (4*i)) & 16'h000F);
                    w = t;
                end
                3'd5: w = {15'd0, ^w};
                3'd6: w = (w << 1) | (w >> 15);
                3'd7: w = w ^ (w >> 8);
                default: ;
            endcase
        end
        return w;
    endfunction

    // Result monitor: every completed output handshake pops one expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", out_data, 'x);
            else                   check("out_data", out_data, exp_q.pop_front());
        end
    end

    // Drive one transaction, check latency, and (if out_ready) let it hand off.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                           input logic [14:0] p, input logic [15:0] exp);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        a_in = a; b_in = b; prog = p; in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); prog = 15'($urandom);
        t = 1;
        while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
        check("latency", t, N + 1);
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    initial begin
        int first, second, cyc, t;
        logic [7:0]  ra, rb;
        logic [14:0] rp;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; prog = '0;
        a2 = '0; b2 = '0; prog2 = '0; in_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_step_idx", step_idx, 0);

        // Default program with a per-step trace of the working word
        a_in = 8'h12; b_in = 8'h34; prog = DEF_PROG; in_valid = 1'b1;
        exp_q.push_back(16'h0001);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("def_capture", out_data, 16'h3412);
        check("def_in_ready_run", in_ready, 0);
        for (int k = 0; k < N; k++) begin
            check("def_valid_early", out_valid, 0);
            @(posedge clk); #1;
            check($sformatf("def_trace%0d", k), out_data, def_trace[k]);
        end
        check("def_valid", out_valid, 1);
        check("def_step_done", step_idx, N - 1);
        @(posedge clk); #1;
        check("def_back_idle", in_ready, 1);
        check("def_valid_drop", out_valid, 0);

        // Directed programs
        run_txn(8'hAB, 8'hCD, {5{SWAP}}, 16'hABCD);
        run_txn(8'hAB, 8'hCD, {5{NOP}},  16'hCDAB);
        run_txn(8'h0F, 8'hF0, {NOP, NOP, NOP, ROTL1, XORH}, 16'hE1FF);

        // Backpressure: hold the result for three cycles, poke in_valid meanwhile
        out_ready = 1'b0;
        run_txn(8'hAB, 8'hCD, {5{SWAP}}, 16'hABCD);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin in_valid = 1'b1; a_in = 8'h55; b_in = 8'h66; end
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 16'hABCD);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        check("bp_step_held", step_idx, N - 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);

        // Reset in the middle of RUN discards the transaction
        a_in = 8'h12; b_in = 8'h34; prog = DEF_PROG; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (step_idx != 2 && t < 20) begin @(posedge clk); #1; t++; end
        check("mid_reach_step2", step_idx, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_step", step_idx, 0);
        run_txn(8'h12, 8'h34, DEF_PROG, 16'h0001);

        // Throughput with in_valid and out_ready held high
        a_in = 8'hAB; b_in = 8'hCD; prog = {5{SWAP}}; in_valid = 1'b1;
        exp_q.push_back(16'hABCD);
        exp_q.push_back(16'hABCD);
        first = -1; second = -1; cyc = 0;
        while (second < 0 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (out_valid) begin
                if (first < 0) first = cyc;
                else begin second = cyc; in_valid = 1'b0; end
            end
        end
        in_valid = 1'b0;
        check("throughput_period", second - first, N + 2);
        @(posedge clk); #1;

        // Random programs against the reference model
        for (int r = 0; r < 8; r++) begin
            ra = 8'($urandom); rb = 8'($urandom); rp = 15'($urandom);
            run_txn(ra, rb, rp, model(ra, rb, rp));
        end

        // 16-bit operand instance
        a2 = 16'h5678; b2 = 16'h1234; prog2 = {NOP, NOP, NOP, NOP, NIBREV}; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        t = 1;
        while (!out_valid2 && t < 100) begin @(posedge clk); #1; t++; end
        check("hw16_valid", out_valid2, 1);
        check("hw16_data", out_data2, 32'h87654321);
        @(posedge clk); #1;

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
